// File: rtl/node_serializer_pkg.sv
// Shared types for the node datapath stages: FSM state encoding, beat
// control bundle and a parameter sanity helper used at elaboration.
package node_serializer_pkg;

  // Serializer occupancy: IDLE holds no word, SEND holds a word with beats pending.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } node_state_e;

  // Per-beat downstream control as seen by the next stage.
  typedef struct packed {
    logic valid;
    logic last;
  } node_beat_ctl_t;

  localparam int NODE_DEFAULT_WIDTH = 32;
  localparam int NODE_DEFAULT_RATIO = 4;

  // A word must split into at least two equal-width beats.
  function automatic bit node_ratio_ok(input int width, input int ratio);
    return (ratio >= 2) && ((width % ratio) == 0);
  endfunction

endpackage

// File: rtl/node_serializer.sv
// Width-down serializer: accepts one WIDTH-bit word upstream and emits it as
// RATIO beats of WIDTH/RATIO bits, least-significant slice first, with a
// last-beat flag. A new word may be taken on the same cycle the final beat
// leaves, so back-to-back words stream without a bubble.
module node_serializer
  import node_serializer_pkg::*;
#(
  parameter int WIDTH = NODE_DEFAULT_WIDTH,
  parameter int RATIO = NODE_DEFAULT_RATIO
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   up_valid_in,
  output logic                   up_ready_out,
  output logic [WIDTH/RATIO-1:0] data_out,
  output logic                   dn_valid_out,
  output logic                   dn_last_out,
  input  logic                   dn_ready_in
);

  localparam int OUT_W = WIDTH / RATIO;
  localparam int CNT_W = $clog2(RATIO);

  if (!node_ratio_ok(WIDTH, RATIO)) begin : g_bad_params
    $error("node_serializer: WIDTH must be a multiple of RATIO and RATIO must be >= 2");
  end

  node_state_e      state;
  node_state_e      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] hold_nxt;
  logic             last_beat;
  logic             up_fire;
  logic             dn_fire;
  node_beat_ctl_t   beat_ctl;

  assign last_beat = (cnt == CNT_W'(RATIO - 1));
  assign up_fire   = up_valid_in & up_ready_out;
  assign dn_fire   = dn_valid_out & dn_ready_in;

  // State, beat counter and held word; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hold  <= hold_nxt;
    end
  end

  // Next state: capture on accept, advance on each delivered beat, and on the
  // final beat either reload from upstream or fall back to IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hold_nxt  = hold;
    case (state)
      IDLE: begin
        if (up_fire) begin
          hold_nxt  = data_in;
          cnt_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (dn_fire) begin
          if (last_beat) begin
            cnt_nxt = '0;
            if (up_fire) begin
              hold_nxt = data_in;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: beat data and valid come from registers only; ready additionally
  // looks at dn_ready_in so the final beat and the next word overlap.
  always_comb begin
    up_ready_out   = 1'b0;
    data_out       = '0;
    beat_ctl.valid = 1'b0;
    beat_ctl.last  = 1'b0;
    case (state)
      IDLE: begin
        up_ready_out = 1'b1;
      end
      SEND: begin
        beat_ctl.valid = 1'b1;
        beat_ctl.last  = last_beat;
        data_out       = hold[OUT_W*cnt +: OUT_W];
        up_ready_out   = last_beat & dn_ready_in;
      end
      default: begin
        up_ready_out = 1'b0;
      end
    endcase
  end

  assign dn_valid_out = beat_ctl.valid;
  assign dn_last_out  = beat_ctl.last;

endmodule

// File: tb/tb_node_serializer.sv
// Bench for node_serializer: directed word/stall/reset scenarios on a 32/4
// instance, then randomized valid/ready traffic on 32/4 and 24/3 instances
// with words reassembled from beats and compared against a queue of accepted
// words.
module tb_node_serializer;

  localparam int NWORDS    = 1000;
  localparam int MAX_CYC   = 60000;

  logic        clk;
  logic        rst_n;
  logic [31:0] din      [2];
  logic        up_valid [2];
  logic        up_ready [2];
  logic [7:0]  dout     [2];
  logic        dn_valid [2];
  logic        dn_last  [2];
  logic        dn_ready [2];

  int checks   = 0;
  int failures = 0;

  node_serializer #(.WIDTH(32), .RATIO(4)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (din[0]),
    .up_valid_in  (up_valid[0]),
    .up_ready_out (up_ready[0]),
    .data_out     (dout[0]),
    .dn_valid_out (dn_valid[0]),
    .dn_last_out  (dn_last[0]),
    .dn_ready_in  (dn_ready[0])
  );

  node_serializer #(.WIDTH(24), .RATIO(3)) u_dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (din[1][23:0]),
    .up_valid_in  (up_valid[1]),
    .up_ready_out (up_ready[1]),
    .data_out     (dout[1]),
    .dn_valid_out (dn_valid[1]),
    .dn_last_out  (dn_last[1]),
    .dn_ready_in  (dn_ready[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Scoreboard state for the randomized phase.
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          ratio     [2];
  int          bidx      [2];
  logic [31:0] acc       [2];
  int          words_in  [2];
  int          words_out [2];
  logic        stall     [2];
  logic [7:0]  prev_data [2];
  logic        prev_last [2];
  logic        accepted  [2];

  task automatic evaluate();
    for (int i = 0; i < 2; i++) begin
      logic        uf;
      logic        df;
      int          qsz;
      logic [31:0] exp_w;
      uf  = up_valid[i] && up_ready[i];
      df  = dn_valid[i] && dn_ready[i];
      qsz = (i == 0) ? exp_q0.size() : exp_q1.size();
      chk("rnd_valid", dn_valid[i], qsz > 0);
      chk("rnd_ready", up_ready[i], (qsz == 0) || ((bidx[i] == ratio[i] - 1) && dn_ready[i]));
      if (stall[i]) begin
        chk("stall_data", dout[i], prev_data[i]);
        chk("stall_last", dn_last[i], prev_last[i]);
      end
      if (!dn_valid[i]) chk("idle_last", dn_last[i], 0);
      stall[i]     = dn_valid[i] && !dn_ready[i];
      prev_data[i] = dout[i];
      prev_last[i] = dn_last[i];
      if (df) begin
        acc[i] = acc[i] | (32'(dout[i]) << (8 * bidx[i]));
        chk("rnd_last", dn_last[i], bidx[i] == ratio[i] - 1);
        if (bidx[i] == ratio[i] - 1) begin
          chk("rnd_qsize", qsz, 1);
          exp_w = 'x;
          if (i == 0 && exp_q0.size() > 0) exp_w = exp_q0.pop_front();
          if (i == 1 && exp_q1.size() > 0) exp_w = exp_q1.pop_front();
          chk("rnd_word", acc[i], exp_w);
          words_out[i]++;
          acc[i]  = '0;
          bidx[i] = 0;
        end else begin
          bidx[i]++;
        end
      end
      accepted[i] = uf;
      if (uf) begin
        if (i == 0) exp_q0.push_back(din[0]);
        else        exp_q1.push_back(din[1] & 32'h00FF_FFFF);
        words_in[i]++;
      end
    end
  endtask

  task automatic drive_random();
    for (int i = 0; i < 2; i++) begin
      if (!up_valid[i] || accepted[i]) begin
        if (words_in[i] < NWORDS) begin
          up_valid[i] = 1'($urandom_range(0, 1));
          din[i]      = (i == 0) ? $urandom : ($urandom & 32'h00FF_FFFF);
        end else begin
          up_valid[i] = 1'b0;
        end
      end
      dn_ready[i] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    logic [31:0] w;
    int          cycles;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din[i] = '0; up_valid[i] = 1'b0; dn_ready[i] = 1'b1;
    end

    // Reset values while rst_n is low, before any clock edge.
    #3;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", up_ready[i], 1);
      chk("rst_valid", dn_valid[i], 0);
      chk("rst_last",  dn_last[i], 0);
      chk("rst_data",  dout[i], 0);
    end
    at_neg(); at_neg();
    rst_n = 1'b1;
    step();

    // Single word, downstream always ready.
    w = 32'hDDCC_BBAA;
    din[0] = w; up_valid[0] = 1'b1; dn_ready[0] = 1'b1;
    at_neg();
    chk("idle_ready", up_ready[0], 1);
    chk("idle_valid", dn_valid[0], 0);
    step();
    up_valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("one_data",  dout[0], (w >> (8 * k)) & 32'hFF);
      chk("one_valid", dn_valid[0], 1);
      chk("one_last",  dn_last[0], k == 3);
      step();
    end
    at_neg();
    chk("one_end_valid", dn_valid[0], 0);
    chk("one_end_last",  dn_last[0], 0);
    chk("one_end_ready", up_ready[0], 1);
    step();

    // Two words back to back; upstream held valid with junk data while not ready.
    din[0] = 32'h0302_0100; up_valid[0] = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i < 3)       din[0] = $urandom;
      else if (i == 3) din[0] = 32'h0706_0504;
      at_neg();
      chk("b2b_data",  dout[0], i);
      chk("b2b_valid", dn_valid[0], 1);
      chk("b2b_last",  dn_last[0], (i % 4) == 3);
      chk("b2b_ready", up_ready[0], (i == 3) || (i == 7));
      step();
      if (i == 3) up_valid[0] = 1'b0;
    end
    at_neg();
    chk("b2b_end_valid", dn_valid[0], 0);
    step();

    // Downstream stall for five cycles on beat 1.
    din[0] = 32'hDDCC_BBAA; up_valid[0] = 1'b1;
    step();
    up_valid[0] = 1'b0;
    at_neg();
    chk("stl_b0", dout[0], 32'hAA);
    step();
    dn_ready[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      chk("stl_hold",  dout[0], 32'hBB);
      chk("stl_valid", dn_valid[0], 1);
      chk("stl_ready", up_ready[0], 0);
      step();
    end
    dn_ready[0] = 1'b1;
    at_neg(); chk("stl_b1", dout[0], 32'hBB); step();
    at_neg(); chk("stl_b2", dout[0], 32'hCC); step();
    at_neg(); chk("stl_b3", dout[0], 32'hDD); chk("stl_last", dn_last[0], 1); step();
    at_neg(); chk("stl_end_valid", dn_valid[0], 0); step();

    // Asynchronous reset after beat 1, then a fresh word from beat 0.
    din[0] = 32'hDDCC_BBAA; up_valid[0] = 1'b1;
    step();
    up_valid[0] = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", dn_valid[0], 0);
    chk("arst_ready", up_ready[0], 1);
    chk("arst_data",  dout[0], 0);
    chk("arst_last",  dn_last[0], 0);
    #2;
    rst_n = 1'b1;
    step();
    w = 32'h4433_2211;
    din[0] = w; up_valid[0] = 1'b1;
    at_neg();
    chk("post_idle_valid", dn_valid[0], 0);
    chk("post_idle_ready", up_ready[0], 1);
    step();
    up_valid[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("post_data", dout[0], (w >> (8 * k)) & 32'hFF);
      chk("post_last", dn_last[0], k == 3);
      step();
    end

    // Randomized traffic on both instances, drained at the end.
    ratio[0] = 4; ratio[1] = 3;
    for (int i = 0; i < 2; i++) begin
      bidx[i] = 0; acc[i] = '0; words_in[i] = 0; words_out[i] = 0;
      stall[i] = 1'b0; prev_data[i] = '0; prev_last[i] = 1'b0; accepted[i] = 1'b0;
      up_valid[i] = 1'b0;
    end
    at_neg();
    step();
    drive_random();
    cycles = 0;
    while (cycles < MAX_CYC &&
           !(words_out[0] == NWORDS && words_out[1] == NWORDS)) begin
      at_neg();
      evaluate();
      step();
      drive_random();
      cycles++;
    end
    chk("rnd_words_in4",  words_in[0], NWORDS);
    chk("rnd_words_in3",  words_in[1], NWORDS);
    chk("rnd_words_out4", words_out[0], NWORDS);
    chk("rnd_words_out3", words_out[1], NWORDS);
    chk("rnd_left4", exp_q0.size(), 0);
    chk("rnd_left3", exp_q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
